// File: rtl/gzip_job_scheduler_pkg.sv
// Shared types and defaults for the gzip job scheduler.
// Request IDs, input FSM states and default sizing live here.
package gzip_job_scheduler_pkg;

  localparam int N_REQ_DEFAULT     = 4;
  localparam int MAX_JOBS_DEFAULT  = 8;
  localparam int DATA_BITS_DEFAULT = 512;

  typedef logic [$clog2(N_REQ_DEFAULT)-1:0] req_id_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } in_state_t;

  // Width of a requester index; never below one bit.
  function automatic int id_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gzip_job_scheduler_tag_fifo.sv
// In-order tag FIFO of requester IDs, one entry per granted job.
// Pointers carry one extra wrap bit to tell full from empty.
module job_tag_fifo
  import gzip_job_scheduler_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = MAX_JOBS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_din,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = $clog2(DEPTH+1)'(r_wr - r_rd);

endmodule

// File: rtl/gzip_job_scheduler.sv
// Shares one compressor between N_REQ AXI4S requesters: round-robin whole-job
// grants on the way in, tag-FIFO routing of compressed jobs on the way out.
module gzip_job_scheduler
  import gzip_job_scheduler_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int MAX_JOBS  = MAX_JOBS_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ*DATA_BITS-1:0]     s_tdata,
  input  logic [N_REQ*DATA_BITS/8-1:0]   s_tkeep,
  input  logic [N_REQ-1:0]               s_tlast,
  input  logic [N_REQ-1:0]               s_tvalid,
  output logic [N_REQ-1:0]               s_tready,
  output logic [DATA_BITS-1:0]           c_in_tdata,
  output logic [DATA_BITS/8-1:0]         c_in_tkeep,
  output logic                           c_in_tlast,
  output logic                           c_in_tvalid,
  input  logic                           c_in_tready,
  input  logic [DATA_BITS-1:0]           c_out_tdata,
  input  logic [DATA_BITS/8-1:0]         c_out_tkeep,
  input  logic                           c_out_tlast,
  input  logic                           c_out_tvalid,
  output logic                           c_out_tready,
  output logic [DATA_BITS-1:0]           m_tdata,
  output logic [DATA_BITS/8-1:0]         m_tkeep,
  output logic                           m_tlast,
  output logic [N_REQ-1:0]               m_tvalid,
  input  logic [N_REQ-1:0]               m_tready,
  output logic [$clog2(MAX_JOBS+1)-1:0]  inflight_jobs,
  output logic                           err_orphan
);

  localparam int KB  = DATA_BITS / 8;
  localparam int IDW = id_bits(N_REQ);

  in_state_t        r_state;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_err;
  logic [IDW-1:0]   w_arb_id;
  logic             w_arb_hit;
  logic [IDW-1:0]   w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_job_end;

  // Round-robin: first requesting index after the last finished grant.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_id  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!w_arb_hit && s_tvalid[(int'(r_rr_ptr) + i) % N_REQ]) begin
        w_arb_hit = 1'b1;
        w_arb_id  = IDW'((int'(r_rr_ptr) + i) % N_REQ);
      end
    end
  end

  assign w_push    = (r_state == IDLE) && w_arb_hit && !w_full;
  assign w_job_end = (r_state == STREAM) && s_tvalid[r_grant] && c_in_tready && s_tlast[r_grant];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= IDW'(N_REQ - 1);
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_push) begin
          r_grant <= w_arb_id;
          r_state <= STREAM;
        end
        STREAM: if (w_job_end) begin
          r_rr_ptr <= r_grant;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_empty && c_out_tvalid) r_err <= 1'b1;
    end
  end

  // Zero-latency input pass-through of the granted requester.
  always_comb begin
    c_in_tdata  = s_tdata[int'(r_grant)*DATA_BITS +: DATA_BITS];
    c_in_tkeep  = s_tkeep[int'(r_grant)*KB +: KB];
    c_in_tlast  = s_tlast[r_grant];
    c_in_tvalid = (r_state == STREAM) && s_tvalid[r_grant];
    s_tready    = '0;
    if (r_state == STREAM) s_tready[r_grant] = c_in_tready;
  end

  // Output routing follows the FIFO head; popped only on the job's last beat.
  always_comb begin
    m_tvalid     = '0;
    c_out_tready = 1'b0;
    if (!w_empty) begin
      m_tvalid[w_head] = c_out_tvalid;
      c_out_tready     = m_tready[w_head];
    end
  end

  assign w_pop = !w_empty && c_out_tvalid && m_tready[w_head] && c_out_tlast;

  assign m_tdata    = c_out_tdata;
  assign m_tkeep    = c_out_tkeep;
  assign m_tlast    = c_out_tlast;
  assign err_orphan = r_err;

  job_tag_fifo #(
    .W     (IDW),
    .DEPTH (MAX_JOBS)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_arb_id),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (inflight_jobs),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_gzip_job_scheduler.sv
// Bench for gzip_job_scheduler: job-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_gzip_job_scheduler;

  localparam int N  = 4;
  localparam int DB = 64;
  localparam int KB = DB / 8;
  localparam int MJ = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DB-1:0] s_tdata;
  logic [N*KB-1:0] s_tkeep;
  logic [N-1:0]    s_tlast, s_tvalid, s_tready;
  logic [DB-1:0]   c_in_tdata;
  logic [KB-1:0]   c_in_tkeep;
  logic            c_in_tlast, c_in_tvalid, c_in_tready;
  logic [DB-1:0]   c_out_tdata;
  logic [KB-1:0]   c_out_tkeep;
  logic            c_out_tlast, c_out_tvalid, c_out_tready;
  logic [DB-1:0]   m_tdata;
  logic [KB-1:0]   m_tkeep;
  logic            m_tlast;
  logic [N-1:0]    m_tvalid, m_tready;
  logic [3:0]      inflight_jobs;
  logic            err_orphan;

  always #5 clk = ~clk;

  gzip_job_scheduler #(.N_REQ(N), .DATA_BITS(DB), .MAX_JOBS(MJ)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .c_in_tdata(c_in_tdata), .c_in_tkeep(c_in_tkeep), .c_in_tlast(c_in_tlast),
    .c_in_tvalid(c_in_tvalid), .c_in_tready(c_in_tready),
    .c_out_tdata(c_out_tdata), .c_out_tkeep(c_out_tkeep), .c_out_tlast(c_out_tlast),
    .c_out_tvalid(c_out_tvalid), .c_out_tready(c_out_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .inflight_jobs(inflight_jobs), .err_orphan(err_orphan)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // stimulus plan
  int       jq[N][$];
  int       bidx[N];
  int       cq[$];
  int       cbidx = 0;
  int       gap_pct = 0, cstall_pct = 0, cgap_pct = 0, mrdy_pct = 100;
  bit       comp_en = 1, auto_comp = 1, orphan_force = 0, mrdy_use_fixed = 0;
  logic     rst_drive = 1'b0;
  logic [N-1:0] mrdy_fixed = '1;
  int       comp_len_fixed = 0;
  logic [N-1:0] acc_s = '0;
  bit       acc_c = 0;

  // reference model: job owner, round-robin pointer, queue of granted owners
  bit  mv = 0;
  bit  m_busy = 0;
  int  m_owner = 0;
  int  m_rr = N - 1;
  int  q[$];
  bit  m_orph = 0;
  int  exp_beats[N];
  int  got_beats[N];
  int  dut_glog[$];
  int  dut_gcyc[$];
  int  cyc_n = 0;

  always @(negedge clk) begin
    logic [N-1:0] e_srdy, e_mv;
    bit   e_civ, e_cor, pop, found;
    int   sz, pick, len;
    cyc_n++;
    acc_s = s_tvalid & s_tready;
    acc_c = c_out_tvalid & c_out_tready;
    for (int r = 0; r < N; r++) if (m_tvalid[r] && m_tready[r]) got_beats[r]++;
    if (c_in_tvalid && c_in_tready && c_in_tlast)
      for (int r = 0; r < N; r++) if (s_tready[r]) begin
        dut_glog.push_back(r);
        dut_gcyc.push_back(cyc_n);
      end
    if (mv) begin
      e_srdy = '0;
      e_civ  = 0;
      if (m_busy) begin
        e_srdy[m_owner] = c_in_tready;
        e_civ = s_tvalid[m_owner];
      end
      chk("s_tready", s_tready, e_srdy);
      chk("c_in_tvalid", c_in_tvalid, e_civ);
      if (e_civ) begin
        chk("c_in_tdata", c_in_tdata, s_tdata[m_owner*DB +: DB]);
        chk("c_in_tkeep", c_in_tkeep, s_tkeep[m_owner*KB +: KB]);
        chk("c_in_tlast", c_in_tlast, s_tlast[m_owner]);
      end
      e_mv  = '0;
      e_cor = 0;
      if (q.size() > 0) begin
        e_mv[q[0]] = c_out_tvalid;
        e_cor = m_tready[q[0]];
      end
      chk("m_tvalid", m_tvalid, e_mv);
      chk("c_out_tready", c_out_tready, e_cor);
      chk("inflight_jobs", inflight_jobs, q.size());
      chk("err_orphan", err_orphan, m_orph);
      if (c_out_tvalid) begin
        chk("m_tdata", m_tdata, c_out_tdata);
        chk("m_tlast", m_tlast, c_out_tlast);
      end
    end
    if (!rst_n) begin
      mv = 1; m_busy = 0; m_rr = N - 1; q.delete(); m_orph = 0;
    end else if (mv) begin
      sz = q.size();
      if (sz == 0 && c_out_tvalid) m_orph = 1;
      pop = (sz > 0) && c_out_tvalid && m_tready[q[0]] && c_out_tlast;
      if (pop) void'(q.pop_front());
      if (!m_busy) begin
        if (s_tvalid != 0 && sz < MJ) begin
          found = 0;
          pick  = 0;
          for (int i = 1; i <= N; i++)
            if (!found && s_tvalid[(m_rr + i) % N]) begin found = 1; pick = (m_rr + i) % N; end
          m_busy = 1; m_owner = pick; q.push_back(pick);
        end
      end else if (s_tvalid[m_owner] && c_in_tready && s_tlast[m_owner]) begin
        m_busy = 0; m_rr = m_owner;
        if (auto_comp) begin
          len = (comp_len_fixed > 0) ? comp_len_fixed : int'($urandom_range(1, 3));
          cq.push_back(len);
          exp_beats[m_owner] += len;
        end
      end
    end
  end

  task automatic drive_all();
    rst_n = rst_drive;
    for (int r = 0; r < N; r++) begin
      if (acc_s[r] && jq[r].size() > 0) begin
        if (s_tlast[r]) begin void'(jq[r].pop_front()); bidx[r] = 0; end
        else bidx[r]++;
      end
      if (jq[r].size() == 0) s_tvalid[r] = 1'b0;
      else if (!(s_tvalid[r] && !acc_s[r])) begin
        s_tvalid[r] = ($urandom_range(99) >= gap_pct);
        s_tdata[r*DB +: DB] = {$urandom, $urandom};
        s_tkeep[r*KB +: KB] = KB'($urandom);
        s_tlast[r] = (bidx[r] == jq[r][0] - 1);
      end
    end
    if (acc_c && cq.size() > 0) begin
      if (c_out_tlast) begin void'(cq.pop_front()); cbidx = 0; end
      else cbidx++;
    end
    if (orphan_force) begin
      c_out_tvalid = 1'b1;
      c_out_tlast  = 1'b1;
    end else if (!comp_en || cq.size() == 0) c_out_tvalid = 1'b0;
    else if (!(c_out_tvalid && !acc_c)) begin
      c_out_tvalid = ($urandom_range(99) >= cgap_pct);
      c_out_tdata  = {$urandom, $urandom};
      c_out_tkeep  = KB'($urandom);
      c_out_tlast  = (cbidx == cq[0] - 1);
    end
    c_in_tready = ($urandom_range(99) >= cstall_pct);
    for (int r = 0; r < N; r++)
      m_tready[r] = mrdy_use_fixed ? mrdy_fixed[r] : ($urandom_range(99) < mrdy_pct);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive_all();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    for (int r = 0; r < N; r++) begin
      jq[r].delete(); bidx[r] = 0; exp_beats[r] = 0; got_beats[r] = 0;
    end
    cq.delete(); cbidx = 0; orphan_force = 0;
    rst_drive = 1'b0;
    cyc(); cyc();
    cq.delete(); cbidx = 0;
    dut_glog.delete(); dut_gcyc.delete();
    for (int r = 0; r < N; r++) begin exp_beats[r] = 0; got_beats[r] = 0; end
    rst_drive = 1'b1;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    int n;
    bit seen;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0;
    c_in_tready = 1'b0; c_out_tdata = '0; c_out_tkeep = '0; c_out_tlast = 1'b0;
    c_out_tvalid = 1'b0; m_tready = '0;
    for (int r = 0; r < N; r++) begin bidx[r] = 0; exp_beats[r] = 0; got_beats[r] = 0; end

    // reset values
    reset_dut();
    chk("rst_s_tready", s_tready, 0);
    chk("rst_c_in_tvalid", c_in_tvalid, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_inflight", inflight_jobs, 0);
    chk("rst_err_orphan", err_orphan, 0);

    // 1: single 3-beat job from req1, 2-beat compressed reply
    comp_len_fixed = 2;
    jq[1].push_back(3);
    cyc();
    chk("t1_ready_idle", s_tready, 4'b0000);
    cyc();
    chk("t1_grant", s_tready, 4'b0010);
    chk("t1_inflight_1", inflight_jobs, 1);
    n = 0;
    for (int i = 0; i < 20 && !(n > 0 && inflight_jobs == 0); i++) begin
      cyc();
      if (c_out_tvalid) begin chk("t1_m_tvalid", m_tvalid, 4'b0010); n++; end
    end
    chk("t1_out_beats", got_beats[1], 2);
    chk("t1_inflight_0", inflight_jobs, 0);

    // 2: all requesters hold 1-beat jobs
    reset_dut();
    jq[0].push_back(1); jq[0].push_back(1);
    for (int r = 1; r < N; r++) jq[r].push_back(1);
    comp_len_fixed = 1;
    for (int i = 0; i < 40 && dut_glog.size() < 5; i++) cyc();
    if (dut_glog.size() < 5) timeout("t2_grants");
    else begin
      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), dut_glog[i], exp_order[i]);
      for (int i = 1; i < 5; i++) chk($sformatf("t2_gap%0d", i), dut_gcyc[i] - dut_gcyc[i-1], 2);
    end
    for (int i = 0; i < 40 && inflight_jobs != 0; i++) cyc();

    // 3: stalled compressor, 9 jobs for 8 slots
    reset_dut();
    comp_en = 0;
    jq[0] = '{1, 1, 1};
    for (int r = 1; r < N; r++) jq[r] = '{1, 1};
    for (int i = 0; i < 30; i++) cyc();
    chk("t3_inflight_full", inflight_jobs, 8);
    for (int i = 0; i < 5; i++) begin cyc(); chk("t3_blocked", s_tready, 0); end
    comp_en = 1;
    for (int i = 0; i < 200 && !(jq[0].size() == 0 && inflight_jobs == 0); i++) cyc();
    if (jq[0].size() != 0 || inflight_jobs != 0) timeout("t3_drain");
    if (dut_glog.size() == 9) chk("t3_ninth_grant", dut_glog[8], 0);
    else timeout("t3_ninth_grant");

    // 4: output job for req2 with m_tready[2] toggling
    reset_dut();
    comp_len_fixed = 3;
    mrdy_use_fixed = 1;
    mrdy_fixed = 4'b1111;
    jq[2].push_back(1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = c_out_tvalid; end
    if (!seen) timeout("t4_out_start");
    for (int i = 0; i < 8; i++) begin
      mrdy_fixed = (i == 0) ? 4'b1011 : 4'b1111;
      cyc();
      if (c_out_tvalid) begin
        chk("t4_c_out_tready", c_out_tready, (i == 0) ? 1'b0 : 1'b1);
        chk("t4_m_tvalid_others", m_tvalid & 4'b1011, 0);
      end
    end
    chk("t4_beats_req2", got_beats[2], 3);
    chk("t4_beats_other", got_beats[0] + got_beats[1] + got_beats[3], 0);
    mrdy_use_fixed = 0;

    // 5: orphan output
    reset_dut();
    orphan_force = 1;
    cyc();
    chk("t5_c_out_tready", c_out_tready, 0);
    chk("t5_err_before", err_orphan, 0);
    orphan_force = 0;
    cyc();
    chk("t5_err_set", err_orphan, 1);
    for (int i = 0; i < 3; i++) begin cyc(); chk("t5_err_sticky", err_orphan, 1); end

    // 6: reset on beat 2 of a 4-beat job
    reset_dut();
    comp_len_fixed = 1;
    jq[1].push_back(4);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      seen = acc_s[1] && (bidx[1] == 0);
    end
    if (!seen) timeout("t6_beat1");
    rst_drive = 1'b0;
    cyc();
    for (int r = 0; r < N; r++) begin jq[r].delete(); bidx[r] = 0; end
    cq.delete(); cbidx = 0;
    rst_drive = 1'b1;
    cyc();
    chk("t6_s_tready", s_tready, 0);
    chk("t6_c_in_tvalid", c_in_tvalid, 0);
    chk("t6_m_tvalid", m_tvalid, 0);
    chk("t6_inflight", inflight_jobs, 0);
    dut_glog.delete();
    jq[0].push_back(1); jq[1].push_back(1);
    for (int i = 0; i < 20 && dut_glog.size() == 0; i++) cyc();
    if (dut_glog.size() == 0) timeout("t6_regrant");
    else chk("t6_first_grant", dut_glog[0], 0);
    for (int i = 0; i < 40 && inflight_jobs != 0; i++) cyc();

    // randomized traffic
    reset_dut();
    comp_len_fixed = 0;
    gap_pct = 30; cstall_pct = 30; cgap_pct = 30; mrdy_pct = 70;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < 6; j++) jq[r].push_back(int'($urandom_range(1, 4)));
    seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      cyc();
      seen = (jq[0].size() + jq[1].size() + jq[2].size() + jq[3].size() == 0)
             && cq.size() == 0 && q.size() == 0 && !m_busy;
    end
    if (!seen) timeout("rand_drain");
    for (int r = 0; r < N; r++) chk($sformatf("rand_beats%0d", r), got_beats[r], exp_beats[r]);
    chk("rand_inflight", inflight_jobs, 0);
    chk("rand_err_orphan", err_orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
